id_decode_pipe: RTL and testbench
=================================

Name: id_decode_pipe

Overview:
Registered, handshaked successor to the combinational instruction-decode stage of the MIPS-32 pipeline. It sits between IF and EX and accepts one 32-bit instruction plus its PC per valid/ready transfer. It classifies the instruction as R/J/HALT/I, splits it into fields, and sign- or zero-extends the immediate. Outputs are held in a single pipeline register. Adds load-use interlock, flush, sticky halt and a stall counter.

Parameters:
PC_W, 32, width of pc_in/pc_out
HAZARD_EN, 1, 1 = load-use interlock active; 0 = hazard inputs ignored
CNT_W, 16, width of stall_cnt (saturating)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  IF presents instruction/pc_in
in_ready  out  1  stage accepts this cycle
instruction  in  32  raw instruction word
pc_in  in  PC_W  PC of instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
flush  in  1  squash held and incoming instruction
ex_load_valid  in  1  EX holds a load (opcode 6'h23)
ex_load_rt  in  5  destination of that load
opcode  out  6  instr[31:26]
rs, rt, rd, sa  out  5 each  register/shift fields
funct  out  6  instr[5:0]
imm16  out  16  instr[15:0]
imm_ext  out  32  sign-extended imm16; zero-extended for andi/ori/xori (6'h0C/0D/0E)
jaddr  out  26  instr[25:0]
instr_type  out  2  R=0, J=1, HALT=2, I=3
pc_out  out  PC_W  PC of held instruction
halted  out  1  sticky HALT flag
stall_cnt  out  CNT_W  cycles lost to hazard stalls

Behaviour:
- Reset: out_valid=0, halted=0, stall_cnt=0; all field outputs, imm_ext, pc_out and instr_type=0. Reset overrides flush and every other input.
- Classification: opcode 0 -> R; 6'h02 -> J; 6'h3F -> HALT; anything else -> I (includes jal 6'h03).
- Fields not used by the type are registered as 0, never stale:
  - R: rs, rt, rd, sa, funct.
  - I: rs, rt, imm16, imm_ext.
  - J: jaddr.
  - HALT: all fields 0.
- hazard = HAZARD_EN & in_valid & ex_load_valid & (ex_load_rt != 0) & (incoming is R or I). It is set when either match holds:
  - incoming rs == ex_load_rt;
  - incoming rt == ex_load_rt, and the instruction is R, beq/bne (6'h04/05) or sw (6'h2B).
- in_ready = !rst & !flush & !halted & !hazard & (!out_valid | out_ready). The expression is combinational; in_ready has no dependency on in_valid.
- Accept (in_valid & in_ready): at the next edge the decoded bundle is loaded and out_valid=1. Latency is 1 cycle.
- Drain (out_valid & out_ready & no accept): out_valid=0 at the next edge.
- Simultaneous drain and accept gives full throughput of 1 instruction per cycle.
- While out_valid & !out_ready, every output holds stable.
- Flush:
  - out_valid=0 at the next edge; the incoming instruction is dropped.
  - If the held instruction is a HALT, halted is cleared.
  - A HALT already drained is not cleared.
- Halt: halted is set at the edge that accepts a HALT. The HALT bundle is still delivered downstream. After that, no further accepts until rst.
- stall_cnt increments on every cycle where hazard=1 and the stage would otherwise be ready. It saturates at all-ones.
- No internal FSM beyond the valid bit and the halted bit. States: EMPTY, FULL, HALTED (orthogonal to EMPTY/FULL).

Decomposition:
- Shared package mips_pkg holds:
  - the instruction-type encodings R/J/HALT/I;
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI, OP_HALT);
  - a decoded-bundle struct.
- One sub-module, id_field_decode: purely combinational; instruction -> type, masked fields, imm_ext, reads_rs/reads_rt flags.
- The top level keeps the register, handshake, hazard, halt and counter logic.

Test Plan:
- add 0x00221820, in_valid=1, out_ready=1 -> next cycle out_valid=1, instr_type=0, rs=1, rt=2, rd=3, sa=0, funct=0x20, imm16=0, jaddr=0.
- addi 0x2025FFFF then ori 0x3425FFFF -> imm_ext 0xFFFFFFFF then 0x0000FFFF, instr_type=3, rt=5, rd=0.
- ex_load_valid=1, ex_load_rt=1, in add 0x00221820 -> in_ready=0 and stall_cnt 0->1. Drop ex_load_valid -> accepted next cycle.
- Same stall with ex_load_rt=0, or with HAZARD_EN=0 -> no stall.
- out_ready=0 for 3 cycles with valid bundle -> outputs stable, in_ready=0. Then release with back-to-back j 0x08000100, lw 0x8C220004 -> jaddr=0x100, then opcode 0x23, one per cycle.
- HALT 0xFC000000 accepted -> halted=1, HALT bundle delivered, in_ready=0 forever.
- Repeat with flush while HALT is held -> halted=0, out_valid=0, accepts resume.
- rst asserted mid-stream with out_valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: instruction-type encodings, opcode constants and the decoded bundle
// shared by the MIPS-32 decode stage.
package mips_pkg;
   typedef enum logic [1:0] {
      T_R    = 2'd0,
      T_J    = 2'd1,
      T_HALT = 2'd2,
      T_I    = 2'd3
   } itype_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sa;
      logic [5:0]  funct;
      logic [15:0] imm16;
      logic [31:0] imm_ext;
      logic [25:0] jaddr;
      itype_e      itype;
   } dec_t;
endpackage

// File: rtl/id_field_decode.sv
// id_field_decode: classifies an instruction word and splits it into fields,
// zeroing every field the instruction type does not use.
module id_field_decode
   import mips_pkg::*;
(
   input  logic [31:0] instr_i,
   output dec_t        dec_o,
   output logic        reads_rt_o
);
   logic [5:0] op;
   logic       is_r, is_i, is_j, zext;
   itype_e     itype;

   always_comb begin
      op    = instr_i[31:26];
      itype = op == OP_RTYPE ? T_R : op == OP_J ? T_J : op == OP_HALT ? T_HALT : T_I;
      is_r  = itype == T_R;
      is_i  = itype == T_I;
      is_j  = itype == T_J;
      zext  = op == OP_ANDI || op == OP_ORI || op == OP_XORI;
      dec_o         = '0;
      dec_o.opcode  = op;
      dec_o.itype   = itype;
      dec_o.rs      = (is_r || is_i) ? instr_i[25:21] : 5'd0;
      dec_o.rt      = (is_r || is_i) ? instr_i[20:16] : 5'd0;
      dec_o.rd      = is_r ? instr_i[15:11] : 5'd0;
      dec_o.sa      = is_r ? instr_i[10:6] : 5'd0;
      dec_o.funct   = is_r ? instr_i[5:0] : 6'd0;
      dec_o.imm16   = is_i ? instr_i[15:0] : 16'd0;
      dec_o.imm_ext = !is_i ? 32'd0 : zext ? {16'd0, instr_i[15:0]} : {{16{instr_i[15]}}, instr_i[15:0]};
      dec_o.jaddr   = is_j ? instr_i[25:0] : 26'd0;
      // rt is a source only for R-type, branches and stores; elsewhere it is a destination
      reads_rt_o    = is_r || op == OP_BEQ || op == OP_BNE || op == OP_SW;
   end
endmodule

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: registered, valid/ready decode stage with load-use interlock,
// flush, sticky halt and a saturating stall counter.
module id_decode_pipe
   import mips_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [PC_W-1:0]  pc_in,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   input  logic             ex_load_valid,
   input  logic [4:0]       ex_load_rt,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       sa,
   output logic [5:0]       funct,
   output logic [15:0]      imm16,
   output logic [31:0]      imm_ext,
   output logic [25:0]      jaddr,
   output logic [1:0]       instr_type,
   output logic [PC_W-1:0]  pc_out,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);
   dec_t             dec_d, dec_q;
   logic             reads_rt, hazard, room, accept, stall;
   logic [PC_W-1:0]  pc_q;
   logic             valid_q, halted_q;
   logic [CNT_W-1:0] cnt_q;

   id_field_decode u_dec (
      .instr_i    (instruction),
      .dec_o      (dec_d),
      .reads_rt_o (reads_rt)
   );

   always_comb begin
      hazard = HAZARD_EN && in_valid && ex_load_valid && ex_load_rt != 5'd0
               && (dec_d.itype == T_R || dec_d.itype == T_I)
               && (dec_d.rs == ex_load_rt || (reads_rt && dec_d.rt == ex_load_rt));
      room   = !rst && !flush && !halted_q && (!valid_q || out_ready);
      stall  = room && hazard;
      accept = in_valid && room && !hazard;
   end

   assign in_ready = room && !hazard;

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_q    <= '0;
         pc_q     <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            dec_q <= dec_d;
            pc_q  <= pc_in;
         end
         valid_q  <= flush ? 1'b0 : accept ? 1'b1 : valid_q && !out_ready;
         // squashing a HALT that never left this stage undoes the halt
         halted_q <= (flush && valid_q && dec_q.itype == T_HALT) ? 1'b0
                   : (accept && dec_d.itype == T_HALT) ? 1'b1 : halted_q;
         if (stall && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid  = valid_q;
   assign opcode     = dec_q.opcode;
   assign rs         = dec_q.rs;
   assign rt         = dec_q.rt;
   assign rd         = dec_q.rd;
   assign sa         = dec_q.sa;
   assign funct      = dec_q.funct;
   assign imm16      = dec_q.imm16;
   assign imm_ext    = dec_q.imm_ext;
   assign jaddr      = dec_q.jaddr;
   assign instr_type = dec_q.itype;
   assign pc_out     = pc_q;
   assign halted     = halted_q;
   assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed vectors and handshake sequences for id_decode_pipe,
// with a second instance (no interlock) and a third (2-bit stall counter).
module tb_id_decode_pipe;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic        ex_load_valid = 1'b0;
   logic [4:0]  ex_load_rt = 5'd0;
   logic [31:0] instruction = 32'd0, pc_in = 32'd0;
   int          total = 0, bad = 0;

   logic        in_ready, out_valid, halted;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm16, stall_cnt;
   logic [31:0] imm_ext, pc_out;
   logic [25:0] jaddr;
   logic [1:0]  instr_type;
   logic [107:0] obus;

   logic        a_rdy, a_ov, a_h, b_rdy, b_ov, b_h;
   logic [5:0]  a_op, a_fn, b_op, b_fn;
   logic [4:0]  a_rs, a_rt, a_rd, a_sa, b_rs, b_rt, b_rd, b_sa;
   logic [15:0] a_im, a_cnt;
   logic [1:0]  b_im_dummy, a_ty, b_ty, b_cnt;
   logic [15:0] b_im;
   logic [31:0] a_ext, a_pc, b_ext, b_pc;
   logic [25:0] a_ja, b_ja;

   always #5 clk = ~clk;

   id_decode_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
      .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt), .opcode(opcode), .rs(rs), .rt(rt),
      .rd(rd), .sa(sa), .funct(funct), .imm16(imm16), .imm_ext(imm_ext), .jaddr(jaddr),
      .instr_type(instr_type), .pc_out(pc_out), .halted(halted), .stall_cnt(stall_cnt));

   id_decode_pipe #(.HAZARD_EN(1'b0)) u_nohaz (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .instruction(instruction),
      .pc_in(pc_in), .out_valid(a_ov), .out_ready(out_ready), .flush(flush),
      .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt), .opcode(a_op), .rs(a_rs), .rt(a_rt),
      .rd(a_rd), .sa(a_sa), .funct(a_fn), .imm16(a_im), .imm_ext(a_ext), .jaddr(a_ja),
      .instr_type(a_ty), .pc_out(a_pc), .halted(a_h), .stall_cnt(a_cnt));

   id_decode_pipe #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy), .instruction(instruction),
      .pc_in(pc_in), .out_valid(b_ov), .out_ready(out_ready), .flush(flush),
      .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt), .opcode(b_op), .rs(b_rs), .rt(b_rt),
      .rd(b_rd), .sa(b_sa), .funct(b_fn), .imm16(b_im), .imm_ext(b_ext), .jaddr(b_ja),
      .instr_type(b_ty), .pc_out(b_pc), .halted(b_h), .stall_cnt(b_cnt));

   assign b_im_dummy = 2'd0;
   assign obus = {opcode, rs, rt, rd, sa, funct, imm16, imm_ext, jaddr, instr_type};

   typedef struct {
      logic [31:0]  ins;
      logic [107:0] exp;
   } vec_t;
   vec_t v[11];

   function automatic logic [107:0] mk(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                       logic [4:0] h, logic [5:0] fn, logic [15:0] im,
                                       logic [31:0] ext, logic [25:0] ja, logic [1:0] ty);
      return {op, s, t, d, h, fn, im, ext, ja, ty};
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [107:0] E_ADD  = 108'd0;
   logic [107:0] e_add, e_j, e_lw, e_halt;

   initial begin
      e_add  = mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 32'h0, 26'h0, 2'd0);
      e_j    = mk(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 32'h0, 26'h100, 2'd1);
      e_lw   = mk(6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h4, 32'h4, 26'h0, 2'd3);
      e_halt = mk(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 32'h0, 26'h0, 2'd2);
      v[0]  = '{32'h00221820, e_add};
      v[1]  = '{32'h2025FFFF, mk(6'h08, 5'd1, 5'd5, 5'd0, 5'd0, 6'h00, 16'hFFFF, 32'hFFFFFFFF, 26'h0, 2'd3)};
      v[2]  = '{32'h3425FFFF, mk(6'h0D, 5'd1, 5'd5, 5'd0, 5'd0, 6'h00, 16'hFFFF, 32'h0000FFFF, 26'h0, 2'd3)};
      v[3]  = '{32'h08000100, e_j};
      v[4]  = '{32'h8C220004, e_lw};
      v[5]  = '{32'h30008001, mk(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h8001, 32'h00008001, 26'h0, 2'd3)};
      v[6]  = '{32'h00021080, mk(6'h00, 5'd0, 5'd2, 5'd2, 5'd2, 6'h00, 16'h0, 32'h0, 26'h0, 2'd0)};
      v[7]  = '{32'h1022FFFE, mk(6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFE, 32'hFFFFFFFE, 26'h0, 2'd3)};
      v[8]  = '{32'h0C000010, mk(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0010, 32'h00000010, 26'h0, 2'd3)};
      v[9]  = '{32'h38438000, mk(6'h0E, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h8000, 32'h00008000, 26'h0, 2'd3)};
      v[10] = '{32'h012A4025, mk(6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h25, 16'h0, 32'h0, 26'h0, 2'd0)};

      tick();
      tick();
      chk("reset_bundle", obus, E_ADD);
      chk("reset_pc", pc_out, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_halted", halted, 0);
      chk("reset_cnt", stall_cnt, 0);
      chk("reset_in_ready", in_ready, 0);
      rst = 1'b0;
      #1 chk("ready_after_reset", in_ready, 1);

      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         instruction = v[i].ins;
         pc_in = 32'h400 + 32'(4 * i);
         #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
         tick();
         chk($sformatf("vec%0d_bundle", i), obus, v[i].exp);
         chk($sformatf("vec%0d_pc", i), pc_out, 32'h400 + 32'(4 * i));
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", out_valid, 0);

      // load-use on rs
      in_valid = 1'b1;
      instruction = 32'h00221820;
      ex_load_valid = 1'b1;
      ex_load_rt = 5'd1;
      #1 chk("haz_rs_ready", in_ready, 0);
      chk("nohaz_inst_ready", a_rdy, 1);
      tick();
      chk("haz_cnt", stall_cnt, 1);
      chk("haz_valid", out_valid, 0);
      chk("nohaz_inst_cnt", a_cnt, 0);
      chk("nohaz_inst_valid", a_ov, 1);
      ex_load_valid = 1'b0;
      #1 chk("haz_release_ready", in_ready, 1);
      tick();
      chk("haz_release_valid", out_valid, 1);
      chk("haz_release_bundle", obus, e_add);
      chk("haz_cnt_hold", stall_cnt, 1);
      ex_load_valid = 1'b1;
      ex_load_rt = 5'd2;
      #1 chk("haz_rt_r_ready", in_ready, 0);
      instruction = 32'h2025FFFF;
      ex_load_rt = 5'd5;
      #1 chk("haz_rt_addi_ready", in_ready, 1);
      instruction = 32'hAC250000;
      #1 chk("haz_rt_sw_ready", in_ready, 0);
      instruction = 32'h00021080;
      ex_load_rt = 5'd0;
      #1 chk("haz_rt0_ready", in_ready, 1);
      ex_load_valid = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("drain2_valid", out_valid, 0);

      // back-pressure then back-to-back
      in_valid = 1'b1;
      instruction = 32'h00221820;
      tick();
      out_ready = 1'b0;
      instruction = 32'h08000100;
      pc_in = 32'h500;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
         tick();
         chk($sformatf("bp%0d_bundle", i), obus, e_add);
         chk($sformatf("bp%0d_valid", i), out_valid, 1);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", in_ready, 1);
      tick();
      chk("b2b_j", obus, e_j);
      chk("b2b_j_pc", pc_out, 32'h500);
      instruction = 32'h8C220004;
      pc_in = 32'h504;
      tick();
      chk("b2b_lw", obus, e_lw);
      chk("b2b_lw_valid", out_valid, 1);
      in_valid = 1'b0;
      tick();

      // halt, drained, then a flush must not clear it
      in_valid = 1'b1;
      out_ready = 1'b0;
      instruction = 32'hFC000000;
      tick();
      chk("halt_flag", halted, 1);
      chk("halt_bundle", obus, e_halt);
      chk("halt_valid", out_valid, 1);
      instruction = 32'h00221820;
      #1 chk("halt_ready", in_ready, 0);
      out_ready = 1'b1;
      tick();
      chk("halt_drained", out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("halt_stuck%0d_ready", i), in_ready, 0);
         chk($sformatf("halt_stuck%0d_valid", i), out_valid, 0);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("halt_drained_flush", halted, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // flush of a held halt clears it and drops the incoming word
      out_ready = 1'b0;
      instruction = 32'hFC000000;
      tick();
      chk("halt2_flag", halted, 1);
      flush = 1'b1;
      #1 chk("flush_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      chk("flush_halted", halted, 0);
      chk("flush_valid", out_valid, 0);
      instruction = 32'h00221820;
      #1 chk("resume_ready", in_ready, 1);
      tick();
      chk("resume_bundle", obus, e_add);
      chk("resume_valid", out_valid, 1);

      // stall counting and saturation
      out_ready = 1'b1;
      ex_load_valid = 1'b1;
      ex_load_rt = 5'd1;
      repeat (5) tick();
      chk("sat_cnt16", stall_cnt, 5);
      chk("sat_cnt2", b_cnt, 3);
      ex_load_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      ex_load_valid = 1'b1;
      repeat (2) tick();
      chk("no_count_when_blocked", stall_cnt, 5);
      ex_load_valid = 1'b0;

      // reset mid-stream
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1 chk("rst_in_ready", in_ready, 0);
      tick();
      chk("rst_bundle", obus, E_ADD);
      chk("rst_pc", pc_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_halted", halted, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
